// File: rtl/bram_port.sv
// Single-port block-RAM wrapper with valid/ready request and response channels and byte enables.
// Define BRAM_PORT_ADDR_CHECK_EN to flag out-of-range addresses on rsp_err.
module bram_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int ENTRIES = READ_LATENCY + 1;
  localparam int PTR_W   = $clog2(ENTRIES);
  localparam int CNT_W   = $clog2(ENTRIES + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(ENTRIES);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(ENTRIES - 1);
  localparam logic [1:0]        AGE_INIT = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] buf_data_q [ENTRIES];
  logic [DATA_WIDTH-1:0] buf_data_d [ENTRIES];
  logic                  buf_err_q  [ENTRIES];
  logic                  buf_err_d  [ENTRIES];
  logic [1:0]            buf_age_q  [ENTRIES];
  logic [1:0]            buf_age_d  [ENTRIES];

  logic                  accept, rsp_fire, in_range, wr_en, err_new;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rd_word, merged_word, rsp_word;

  assign req_ready = (cnt_q < CNT_FULL);
  assign rsp_valid = (cnt_q != '0) && (buf_age_q[rd_ptr_q] == 2'd0);
  assign rsp_rdata = rsp_valid ? buf_data_q[rd_ptr_q] : '0;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign idx       = req_addr[IDX_W-1:0];
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);

`ifdef BRAM_PORT_ADDR_CHECK_EN
  assign err_new = ~in_range;
  assign rsp_err = rsp_valid && buf_err_q[rd_ptr_q];
`else
  assign err_new = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Access stage: memory already holds every earlier accepted write, so the
  // combinational read here is the ordering point for read-after-write.
  always_comb begin
    rd_word     = in_range ? mem_q[idx] : '0;
    merged_word = merge_bytes(rd_word, req_wdata, req_be);
    rsp_word    = in_range ? (req_we ? merged_word : rd_word) : '0;
    wr_en       = accept && req_we && in_range && !rst;
  end

  // Response buffer: each entry ages down to zero before it may be presented.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_err_d  = buf_err_q;
    buf_age_d  = buf_age_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (buf_age_q[i] != 2'd0) buf_age_d[i] = buf_age_q[i] - 2'd1;
    end
    if (accept) begin
      buf_data_d[wr_ptr_q] = rsp_word;
      buf_err_d[wr_ptr_q]  = err_new;
      buf_age_d[wr_ptr_q]  = AGE_INIT;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = accept   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rsp_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({accept, rsp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_err_q  <= buf_err_d;
    buf_age_q  <= buf_age_d;
    if (wr_en) mem_q[idx] <= merged_word;
  end

endmodule

// File: doc/bram_port.md
BRAM_PORT -- requirements
Module: bram_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words; 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, accept-to-earliest-response cycles; 1..4.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  request can be accepted.
REQ-009 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_be  input  DATA_WIDTH/8  byte write enables; bit i covers byte i.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  word address.
REQ-012 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-015 SHALL have port rsp_rdata  output  DATA_WIDTH  read data, or merged word for writes.
REQ-016 SHALL have port rsp_err  output  1  address error flag; see Configuration.

Function
REQ-017 Request accepted in a cycle iff req_valid && req_ready at the rising edge; response handshake iff rsp_valid && rsp_ready.
REQ-018 Every accepted request, read or write, SHALL produce exactly one response; responses strictly in acceptance order.
REQ-019 Write: at the accept edge, bytes with req_be[i]=1 SHALL be updated; other bytes unchanged; req_be=0 still acknowledged.
REQ-020 Write response rsp_rdata SHALL equal the post-write word (write-through).
REQ-021 Read response rsp_rdata SHALL equal the word contents after all writes accepted earlier; a read accepted the cycle after a write to the same address returns the new data.
REQ-022 Request accepted at edge N SHALL give rsp_valid=1 no earlier than cycle N+READ_LATENCY, and exactly then when no older response is stalled.
REQ-023 An outstanding counter SHALL track accepted-but-unconsumed responses, range 0..READ_LATENCY+1; +1 on accept, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-024 Internal response buffering SHALL hold READ_LATENCY+1 entries; no response is ever dropped or overwritten.
REQ-025 req_ready SHALL be 1 iff the registered outstanding count < READ_LATENCY+1; no combinational path from req_valid or rsp_ready to req_ready.
REQ-026 With rsp_ready=0, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until the handshake.
REQ-027 With rsp_ready held 1, the block SHALL sustain one accepted request per cycle.
REQ-028 Memory contents SHALL NOT be reset; out-of-range addresses (>= DEPTH) SHALL never modify memory.

Reset
REQ-029 While rst=1 at an edge: outstanding=0, all pipeline and buffer entries invalid, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from the following cycle.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered responses; a write accepted at the same edge as rst=1 SHALL NOT be performed.

Configuration
REQ-031 Macro BRAM_PORT_ADDR_CHECK_EN defined: request with req_addr >= DEPTH SHALL respond with rsp_err=1 and rsp_rdata=0; no write; in-range responses rsp_err=0.
REQ-032 Macro not defined: rsp_err SHALL be constant 0; out-of-range reads return 0; out-of-range writes ignored.

Verification
REQ-033 Defaults; write addr 5 data 0xDEADBEEF be=0xF; then read addr 5 -> write rsp 0xDEADBEEF at N+1, read rsp 0xDEADBEEF at N+2.
REQ-034 Addr 7 = 0x11223344; write 0xAABBCCDD be=0x5 -> rsp_rdata 0x11BB33DD; subsequent read -> 0x11BB33DD.
REQ-035 READ_LATENCY=3, rsp_ready=0, req_valid held 1 -> exactly 4 accepted then req_ready=0; release rsp_ready -> 4 responses in order, no loss.
REQ-036 READ_LATENCY=2, back-to-back reads addr 0..9 with rsp_ready=1 -> req_ready stays 1, 10 in-order responses, first at accept+2.
REQ-037 rst=1 with 3 responses outstanding -> next cycle rsp_valid=0, req_ready=1, memory contents retained.
REQ-038 DEPTH=1000, BRAM_PORT_ADDR_CHECK_EN defined, write addr 1020 -> rsp_err=1, rsp_rdata=0; macro undefined -> rsp_err=0, rsp_rdata=0; memory unchanged in both.
